// File: rtl/clk_test_pkg.sv
// Shared constants and helpers for the clk_test frequency counter.
// Holds the default window length and the result width used by clk_test.
package clk_test_pkg;

    localparam int unsigned DEFAULT_REF_CYCLES = 96000000;
    localparam int          FREQ_W             = 32;

    localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

    // Counts stick at all-ones instead of wrapping back to a small, misleading value.
    function automatic logic [FREQ_W-1:0] sat_inc(input logic [FREQ_W-1:0] value,
                                                  input logic              inc);
        sat_inc = (inc && (value != FREQ_MAX)) ? value + FREQ_W'(1) : value;
    endfunction

endpackage

// File: rtl/clk_test_edge_sync.sv
// Brings the asynchronous measured clock into the clk domain.
// Emits a one-cycle pulse per synchronized rising edge.
module clk_test_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Comparing against the registered previous sample yields exactly one pulse per edge.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/clk_test.sv
// Measures sysclk by counting its rising edges over a window of REF_CYCLES clk cycles.
// Define CLK_TEST_VALID_EN to add the freq_valid update strobe.
module clk_test
    import clk_test_pkg::*;
#(
    parameter int unsigned REF_CYCLES  = clk_test_pkg::DEFAULT_REF_CYCLES,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sysclk,
    output logic [clk_test_pkg::FREQ_W-1:0] snes_sysclk_freq
`ifdef CLK_TEST_VALID_EN
    ,
    output logic                            freq_valid
`endif
);

    localparam int               WIN_W    = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(REF_CYCLES - 1);

    logic [WIN_W-1:0]  r_win;
    logic [FREQ_W-1:0] r_edge_cnt;
    logic              w_rise;
    logic              w_win_last;

    clk_test_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sysclk),
        .o_rise  (w_rise)
    );

    assign w_win_last = (r_win == WIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_win_last) begin
            r_win <= '0;
        end else begin
            r_win <= r_win + WIN_W'(1);
        end
    end

    // An edge on the closing cycle goes into the published result, never into the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt       <= '0;
            snes_sysclk_freq <= '0;
        end else if (w_win_last) begin
            r_edge_cnt       <= '0;
            snes_sysclk_freq <= sat_inc(r_edge_cnt, w_rise);
        end else begin
            r_edge_cnt       <= sat_inc(r_edge_cnt, w_rise);
        end
    end

`ifdef CLK_TEST_VALID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= w_win_last;
        end
    end
`endif

endmodule

// File: tb/tb_clk_test.sv
// Directed bench for clk_test with a 100-cycle window and a 2-stage synchronizer.
// Checks periodic and static sysclk, window-boundary edges and mid-window reset.
module tb_clk_test;

    localparam int unsigned REF = 100;

    typedef struct {
        string       name;
        int          halfPeriod;
        logic        level;
        logic [31:0] expFreq;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        sysclk;
    logic [31:0] freq;
`ifdef CLK_TEST_VALID_EN
    logic        freqValid;
`endif

    int passed;
    int total;
    int cyc;
    int halfP;
    int phase;

    clk_test #(
        .REF_CYCLES  (REF),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sysclk           (sysclk),
        .snes_sysclk_freq (freq)
`ifdef CLK_TEST_VALID_EN
        ,
        .freq_valid       (freqValid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk cycle: sample just after the rising edge, then move sysclk on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
`ifdef CLK_TEST_VALID_EN
        checkOutput($sformatf("valid@%0d", cyc), {31'd0, freqValid},
                    {31'd0, ((cyc % REF) == 0)});
`endif
        @(negedge clk);
        if (halfP > 0) begin
            phase++;
            if (phase == halfP) begin
                phase  = 0;
                sysclk = ~sysclk;
            end
        end
    endtask

    task automatic runTo(input int target);
        while (cyc < target) tick();
    endtask

    task automatic applyStimulus(input int hp, input logic lvl);
        @(negedge clk);
        rst_n  = 1'b0;
        sysclk = lvl;
        halfP  = hp;
        phase  = 0;
        #1;
        checkOutput("freq_in_reset", freq, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    vec_t vecs[6];

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        halfP  = 0;
        phase  = 0;
        rst_n  = 1'b0;
        sysclk = 1'b0;

        vecs[0] = '{name: "period10", halfPeriod: 5,  level: 1'b0, expFreq: 32'd10};
        vecs[1] = '{name: "period20", halfPeriod: 10, level: 1'b0, expFreq: 32'd5};
        vecs[2] = '{name: "period4",  halfPeriod: 2,  level: 1'b0, expFreq: 32'd25};
        vecs[3] = '{name: "period2",  halfPeriod: 1,  level: 1'b0, expFreq: 32'd50};
        vecs[4] = '{name: "static0",  halfPeriod: 0,  level: 1'b0, expFreq: 32'd0};
        vecs[5] = '{name: "static1",  halfPeriod: 0,  level: 1'b1, expFreq: 32'd0};

        #2;
        checkOutput("freq_at_power_on", freq, 32'd0);
`ifdef CLK_TEST_VALID_EN
        checkOutput("valid_at_power_on", {31'd0, freqValid}, 32'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].halfPeriod, vecs[i].level);
            runTo(200);
            checkOutput({vecs[i].name, "_win2"}, freq, vecs[i].expFreq);
            runTo(250);
            checkOutput({vecs[i].name, "_hold"}, freq, vecs[i].expFreq);
            runTo(300);
            checkOutput({vecs[i].name, "_win3"}, freq, vecs[i].expFreq);
        end

        // High at reset release: the synchronizer sees a 0->1 step inside window 1.
        applyStimulus(0, 1'b1);
        runTo(99);
        checkOutput("high_release_pre", freq, 32'd0);
        runTo(100);
        checkOutput("high_release_win1", freq, 32'd1);
        runTo(200);
        checkOutput("high_release_win2", freq, 32'd0);

        // Rise sampled at E198 -> pulse on E200, the closing cycle of window 2.
        applyStimulus(0, 1'b0);
        runTo(197);
        sysclk = 1'b1;
        runTo(200);
        checkOutput("last_cycle_edge_win2", freq, 32'd1);
        runTo(300);
        checkOutput("last_cycle_edge_win3", freq, 32'd0);

        // Rise sampled at E199 -> pulse on E201, the first cycle of window 3.
        applyStimulus(0, 1'b0);
        runTo(198);
        sysclk = 1'b1;
        runTo(200);
        checkOutput("first_cycle_edge_win2", freq, 32'd0);
        runTo(300);
        checkOutput("first_cycle_edge_win3", freq, 32'd1);
        runTo(400);
        checkOutput("first_cycle_edge_win4", freq, 32'd0);

        // Mid-window reset: result clears at once and the partial count is dropped.
        applyStimulus(5, 1'b0);
        runTo(250);
        checkOutput("pre_reset_freq", freq, 32'd10);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", freq, 32'd0);
`ifdef CLK_TEST_VALID_EN
        checkOutput("async_reset_valid", {31'd0, freqValid}, 32'd0);
`endif
        halfP  = 0;
        sysclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        runTo(40);
        sysclk = 1'b1;
        runTo(99);
        checkOutput("post_reset_no_early_update", freq, 32'd0);
        runTo(100);
        checkOutput("post_reset_update_at_100", freq, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
